seg7_scan_drv: RTL

Parametrised, time-multiplexed driver for a common-anode bank of NUM_DIGITS seven-segment displays, sitting between the clock/date datapath and the board pins. Decodes BCD or hex nibbles, applies leading-zero blanking, per-digit blink and decimal points. Scans one digit at a time with an anti-ghosting guard interval. Double-buffers the display value so updates land only on frame boundaries, so the display never tears.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_hex_dec.sv | 35 +++
 rtl/seg7_scan_drv.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns {g,f,e,d,c,b,a} and a counter-width helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b100_0000;
    localparam logic [6:0] SEG_1     = 7'b111_1001;
    localparam logic [6:0] SEG_2     = 7'b010_0100;
    localparam logic [6:0] SEG_3     = 7'b011_0000;
    localparam logic [6:0] SEG_4     = 7'b001_1001;
    localparam logic [6:0] SEG_5     = 7'b001_0010;
    localparam logic [6:0] SEG_6     = 7'b000_0010;
    localparam logic [6:0] SEG_7     = 7'b111_1000;
    localparam logic [6:0] SEG_8     = 7'b000_0000;
    localparam logic [6:0] SEG_9     = 7'b001_0000;
    localparam logic [6:0] SEG_A     = 7'b000_1000;
    localparam logic [6:0] SEG_B     = 7'b000_0011;
    localparam logic [6:0] SEG_C     = 7'b100_0110;
    localparam logic [6:0] SEG_D     = 7'b010_0001;
    localparam logic [6:0] SEG_E     = 7'b000_0110;
    localparam logic [6:0] SEG_F     = 7'b000_1110;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational nibble-to-segment decoder; in BCD mode values above 9 blank.
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_hex_mode,
    output logic [6:0] o_seg_n
);

    always_comb begin
        o_seg_n = SEG_BLANK;
        unique case (i_nib)
            4'h0: o_seg_n = SEG_0;
            4'h1: o_seg_n = SEG_1;
            4'h2: o_seg_n = SEG_2;
            4'h3: o_seg_n = SEG_3;
            4'h4: o_seg_n = SEG_4;
            4'h5: o_seg_n = SEG_5;
            4'h6: o_seg_n = SEG_6;
            4'h7: o_seg_n = SEG_7;
            4'h8: o_seg_n = SEG_8;
            4'h9: o_seg_n = SEG_9;
            4'hA: o_seg_n = SEG_A;
            4'hB: o_seg_n = SEG_B;
            4'hC: o_seg_n = SEG_C;
            4'hD: o_seg_n = SEG_D;
            4'hE: o_seg_n = SEG_E;
            4'hF: o_seg_n = SEG_F;
        endcase
        if (!i_hex_mode && (i_nib > 4'd9)) begin
            o_seg_n = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan_drv.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous
// double buffering, leading-zero blanking, blink and anti-ghosting guard.
module seg7_scan_drv
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 6,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned GUARD        = 2,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_digits_in,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic [NUM_DIGITS-1:0]   i_blink_mask,
    input  logic                    i_hex_mode,
    input  logic                    i_lz_blank,
    output logic [6:0]              o_seg_n,
    output logic                    o_dp_n,
    output logic [NUM_DIGITS-1:0]   o_an_n,
    output logic                    o_frame_tick,
    output logic                    o_pending
);

    localparam int unsigned PCNT_W = cnt_w(SCAN_DIV);
    localparam int unsigned IDX_W  = cnt_w(NUM_DIGITS);
    localparam int unsigned BCNT_W = cnt_w(BLINK_FRAMES);

    logic [PCNT_W-1:0]       r_pcnt;
    logic [IDX_W-1:0]        r_idx;
    logic [BCNT_W-1:0]       r_bcnt;
    logic                    r_phase;
    logic [4*NUM_DIGITS-1:0] r_stg_digits;
    logic [NUM_DIGITS-1:0]   r_stg_dp;
    logic [NUM_DIGITS-1:0]   r_stg_blink;
    logic                    r_pending;
    logic [4*NUM_DIGITS-1:0] r_act_digits;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_blink;
    logic [6:0]              r_seg_n;
    logic                    r_dp_n;
    logic [NUM_DIGITS-1:0]   r_an_n;
    logic                    r_frame_tick;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic [3:0]              w_cur_nib;
    logic                    w_cur_dp;
    logic                    w_cur_blink;
    logic                    w_upper_zero;
    logic                    w_lz_hit;
    logic                    w_blink_off;
    logic [6:0]              w_dec_seg;
    logic [NUM_DIGITS-1:0]   w_an_n;

    assign w_slot_end  = (r_pcnt == PCNT_W'(SCAN_DIV - 1));
    assign w_frame_end = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));

    // Select the active digit's fields and evaluate leading-zero suppression:
    // walk from the MSB down, tracking whether every nibble so far is zero.
    always_comb begin
        w_cur_nib    = 4'h0;
        w_cur_dp     = 1'b0;
        w_cur_blink  = 1'b0;
        w_upper_zero = 1'b1;
        w_lz_hit     = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero && (r_act_digits[4*i +: 4] == 4'h0);
            if (r_idx == IDX_W'(i)) begin
                w_cur_nib   = r_act_digits[4*i +: 4];
                w_cur_dp    = r_act_dp[i];
                w_cur_blink = r_act_blink[i];
                w_lz_hit    = (i > 0) && w_upper_zero;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_an_n[i] = (r_pcnt < PCNT_W'(GUARD)) || (r_idx != IDX_W'(i));
        end
    end

    assign w_blink_off = r_phase && w_cur_blink;

    seg7_hex_dec u_dec (
        .i_nib      (w_cur_nib),
        .i_hex_mode (i_hex_mode),
        .o_seg_n    (w_dec_seg)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pcnt       <= '0;
            r_idx        <= '0;
            r_bcnt       <= '0;
            r_phase      <= 1'b0;
            r_stg_digits <= '0;
            r_stg_dp     <= '0;
            r_stg_blink  <= '0;
            r_pending    <= 1'b0;
            r_act_digits <= '0;
            r_act_dp     <= '0;
            r_act_blink  <= '0;
            r_seg_n      <= SEG_BLANK;
            r_dp_n       <= 1'b1;
            r_an_n       <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_pcnt <= '0;
                r_idx  <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
            end

            r_frame_tick <= w_frame_end;

            // Commit takes the pre-edge staging, so a coincident load waits a frame.
            if (w_frame_end) begin
                if (r_pending) begin
                    r_act_digits <= r_stg_digits;
                    r_act_dp     <= r_stg_dp;
                    r_act_blink  <= r_stg_blink;
                end
                if (r_bcnt == BCNT_W'(BLINK_FRAMES - 1)) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end

            if (i_load) begin
                r_stg_digits <= i_digits_in;
                r_stg_dp     <= i_dp_in;
                r_stg_blink  <= i_blink_mask;
                r_pending    <= 1'b1;
            end else if (w_frame_end) begin
                r_pending <= 1'b0;
            end

            r_seg_n <= ((i_lz_blank && w_lz_hit) || w_blink_off) ? SEG_BLANK : w_dec_seg;
            r_dp_n  <= ~(w_cur_dp && !w_blink_off);
            r_an_n  <= w_an_n;
        end
    end

    assign o_seg_n      = r_seg_n;
    assign o_dp_n       = r_dp_n;
    assign o_an_n       = r_an_n;
    assign o_frame_tick = r_frame_tick;
    assign o_pending    = r_pending;

endmodule
